// File: rtl/button_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// button_conditioner_pkg
//   Shared definitions for the button conditioner:
//     - 2-bit debounce FSM state encodings
//     - DEBOUNCE_CYCLES derivation from clock frequency and stability window
//     - counter width helper
//   Optional feature macro used by the block: BUTTON_CONDITIONER_LONG_PRESS_EN
// -----------------------------------------------------------------------------
package button_conditioner_pkg;

    localparam logic [1:0] ST_RELEASED  = 2'd0;
    localparam logic [1:0] ST_CHK_PRESS = 2'd1;
    localparam logic [1:0] ST_PRESSED   = 2'd2;
    localparam logic [1:0] ST_CHK_REL   = 2'd3;

    // Integer MHz first, so the result matches the documented formula exactly.
    function automatic int unsigned debounce_cycles(input int unsigned clock_hz,
                                                    input int unsigned time_us);
        return (clock_hz / 1000000) * time_us;
    endfunction

    // Width able to hold 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
//   One button channel: polarity normalise, two-flop synchroniser, counter
//   based debounce FSM, registered press/release pulses and, when
//   BUTTON_CONDITIONER_LONG_PRESS_EN is defined, a saturating hold counter
//   producing a single long-press pulse per press.
// Ports
//   i_clock        system clock
//   i_reset        asynchronous active-low reset
//   i_raw          raw asynchronous button pin
//   o_level        debounced level, 1 = pressed
//   o_press        1-cycle pulse when the level rises
//   o_release      1-cycle pulse when the level falls
//   o_long_press   1-cycle long-press pulse (0 when the macro is undefined)
// -----------------------------------------------------------------------------
module debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES    = 8,
    parameter int unsigned BUTTON_ACTIVE_HIGH = 1,
    parameter int unsigned LONG_PRESS_CYCLES  = 20
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long_press
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_chk_debounce
        $error("DEBOUNCE_CYCLES must be >= 2");
    end
    if (LONG_PRESS_CYCLES < 2) begin : g_chk_long
        $error("LONG_PRESS_CYCLES must be >= 2");
    end

    logic          w_norm;
    logic          w_s;
    logic          r_sync1, r_sync2;
    logic [1:0]    r_state, w_state_d;
    logic [CW-1:0] r_count, w_count_d;
    logic          r_level, w_level_d;
    logic          r_press, w_press_d;
    logic          r_release, w_release_d;

    assign w_norm = (BUTTON_ACTIVE_HIGH != 0) ? i_raw : ~i_raw;
    assign w_s    = r_sync2;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_state   <= ST_RELEASED;
            r_count   <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= w_norm;
            r_sync2   <= r_sync1;
            r_state   <= w_state_d;
            r_count   <= w_count_d;
            r_level   <= w_level_d;
            r_press   <= w_press_d;
            r_release <= w_release_d;
        end
    end

    // Any disagreement of s during a check aborts it with the count cleared.
    always_comb begin
        w_state_d   = r_state;
        w_count_d   = r_count;
        w_level_d   = r_level;
        w_press_d   = 1'b0;
        w_release_d = 1'b0;
        case (r_state)
            ST_RELEASED: begin
                if (w_s) begin
                    w_state_d = ST_CHK_PRESS;
                    w_count_d = '0;
                end
            end
            ST_CHK_PRESS: begin
                if (!w_s) begin
                    w_state_d = ST_RELEASED;
                    w_count_d = '0;
                end else if (r_count == CNT_LAST) begin
                    w_state_d = ST_PRESSED;
                    w_count_d = '0;
                    w_level_d = 1'b1;
                    w_press_d = 1'b1;
                end else begin
                    w_count_d = r_count + CW'(1);
                end
            end
            ST_PRESSED: begin
                if (!w_s) begin
                    w_state_d = ST_CHK_REL;
                    w_count_d = '0;
                end
            end
            ST_CHK_REL: begin
                if (w_s) begin
                    w_state_d = ST_PRESSED;
                    w_count_d = '0;
                end else if (r_count == CNT_LAST) begin
                    w_state_d   = ST_RELEASED;
                    w_count_d   = '0;
                    w_level_d   = 1'b0;
                    w_release_d = 1'b1;
                end else begin
                    w_count_d = r_count + CW'(1);
                end
            end
            default: begin
                w_state_d = ST_RELEASED;
                w_count_d = '0;
            end
        endcase
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
    localparam int unsigned HW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);

    logic [HW-1:0] r_hold;
    logic          r_long;
    logic          w_enter_pressed;

    // Only a fresh debounced press restarts timing; a bounce back from CHK_REL does not.
    assign w_enter_pressed = (r_state == ST_CHK_PRESS) && (w_state_d == ST_PRESSED);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_hold <= '0;
            r_long <= 1'b0;
        end else begin
            // Saturation at HOLD_MAX guarantees a single pulse per press.
            r_long <= (r_state == ST_PRESSED) && (r_hold == HOLD_LAST);
            if (w_enter_pressed) begin
                r_hold <= '0;
            end else if ((r_state == ST_PRESSED) && (r_hold != HOLD_MAX)) begin
                r_hold <= r_hold + HW'(1);
            end
        end
    end

    assign o_long_press = r_long;
`else
    assign o_long_press = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//   Board-level input stage between raw push-buttons and rvsteel_soc.
//   One debounce_channel per button; this level only adds the stretched,
//   active-high soc_reset driven by button 0 and the board reset.
//   Optional feature macro: BUTTON_CONDITIONER_LONG_PRESS_EN (long-press pulses).
// Ports
//   i_clock              system clock
//   i_reset              asynchronous active-low board reset
//   i_button_raw         raw asynchronous button pins
//   o_button_level       debounced levels, 1 = pressed
//   o_button_press       1-cycle pulses on debounced press
//   o_button_release     1-cycle pulses on debounced release
//   o_button_long_press  1-cycle long-press pulses (0 without the macro)
//   o_soc_reset          active-high reset for rvsteel_soc
// -----------------------------------------------------------------------------
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY      = 50000000,
    parameter int unsigned DEBOUNCE_TIME_US     = 10000,
    parameter int unsigned NUM_BUTTONS          = 2,
    parameter int unsigned BUTTON_ACTIVE_HIGH   = 1,
    parameter int unsigned RESET_STRETCH_CYCLES = 16,
    parameter int unsigned LONG_PRESS_CYCLES    = 50000000
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic [NUM_BUTTONS-1:0] i_button_raw,
    output logic [NUM_BUTTONS-1:0] o_button_level,
    output logic [NUM_BUTTONS-1:0] o_button_press,
    output logic [NUM_BUTTONS-1:0] o_button_release,
    output logic [NUM_BUTTONS-1:0] o_button_long_press,
    output logic                   o_soc_reset
);

    localparam int unsigned DEBOUNCE_CYCLES = debounce_cycles(CLOCK_FREQUENCY, DEBOUNCE_TIME_US);
    localparam int unsigned SW = $clog2(RESET_STRETCH_CYCLES + 1);
    localparam logic [SW-1:0] STRETCH_LOAD = SW'(RESET_STRETCH_CYCLES);

    if (NUM_BUTTONS < 1) begin : g_chk_buttons
        $error("NUM_BUTTONS must be >= 1");
    end
    if (RESET_STRETCH_CYCLES < 1) begin : g_chk_stretch
        $error("RESET_STRETCH_CYCLES must be >= 1");
    end

    logic [NUM_BUTTONS-1:0] w_level;
    logic [SW-1:0]          r_stretch;
    logic                   r_soc_reset;

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
            .BUTTON_ACTIVE_HIGH (BUTTON_ACTIVE_HIGH),
            .LONG_PRESS_CYCLES  (LONG_PRESS_CYCLES)
        ) u_chan (
            .i_clock      (i_clock),
            .i_reset      (i_reset),
            .i_raw        (i_button_raw[g]),
            .o_level      (w_level[g]),
            .o_press      (o_button_press[g]),
            .o_release    (o_button_release[g]),
            .o_long_press (o_button_long_press[g])
        );
    end

    // The counter is held at its load value while button 0 is down, so the
    // countdown starts on the edge where level[0] falls.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_stretch   <= STRETCH_LOAD;
            r_soc_reset <= 1'b1;
        end else if (w_level[0]) begin
            r_stretch   <= STRETCH_LOAD;
            r_soc_reset <= 1'b1;
        end else if (r_stretch != '0) begin
            r_stretch   <= r_stretch - SW'(1);
            r_soc_reset <= (r_stretch != SW'(1));
        end else begin
            r_soc_reset <= 1'b0;
        end
    end

    // OR with level[0] so soc_reset rises in the same cycle as the debounced press.
    assign o_soc_reset    = r_soc_reset | w_level[0];
    assign o_button_level = w_level;

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] raw;
    logic [1:0] level, press, release_p, long_p;
    logic       soc_reset;

    always #5 clk = ~clk;

    button_conditioner #(
        .CLOCK_FREQUENCY      (1000000),
        .DEBOUNCE_TIME_US     (8),
        .NUM_BUTTONS          (2),
        .BUTTON_ACTIVE_HIGH   (1),
        .RESET_STRETCH_CYCLES (4),
        .LONG_PRESS_CYCLES    (20)
    ) dut (
        .i_clock             (clk),
        .i_reset             (rst_n),
        .i_button_raw        (raw),
        .o_button_level      (level),
        .o_button_press      (press),
        .o_button_release    (release_p),
        .o_button_long_press (long_p),
        .o_soc_reset         (soc_reset)
    );

    typedef struct {
        logic        rst_n;
        logic [1:0]  raw;
        int unsigned wait_n;
        logic [1:0]  lvl;
        logic [1:0]  prs;
        logic [1:0]  rel;
        logic        soc;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad = 0;
    int   press_cnt[2] = '{0, 0};
    int   rel_cnt[2] = '{0, 0};
    int   long_cnt[2] = '{0, 0};

    // Pulse totals over the whole run catch spurious or doubled pulses between samples.
    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (press[c] === 1'b1) press_cnt[c]++;
            if (release_p[c] === 1'b1) rel_cnt[c]++;
            if (long_p[c] === 1'b1) long_cnt[c]++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic r, input logic [1:0] rw, input int unsigned w,
                                input logic [1:0] l, input logic [1:0] p, input logic [1:0] rl,
                                input logic s);
        vec_t v;
        v.rst_n = r; v.raw = rw; v.wait_n = w;
        v.lvl = l; v.prs = p; v.rel = rl; v.soc = s;
        vecs.push_back(v);
    endfunction

    task automatic run_vecs(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            rst_n = vecs[i].rst_n;
            raw   = vecs[i].raw;
            repeat (vecs[i].wait_n) @(negedge clk);
            check($sformatf("v%0d level", i), 32'(level), 32'(vecs[i].lvl));
            check($sformatf("v%0d press", i), 32'(press), 32'(vecs[i].prs));
            check($sformatf("v%0d release", i), 32'(release_p), 32'(vecs[i].rel));
            check($sformatf("v%0d soc_reset", i), 32'(soc_reset), 32'(vecs[i].soc));
            check($sformatf("v%0d long_press", i), 32'(long_p), 32'd0);
        end
    endtask

    int split;
    int lp_count;
    int lp_at;
    int exp_long;
    int exp_long_at;

    initial begin
        rst_n = 1'b0;
        raw   = 2'b00;

        // 1: reset then idle; soc_reset stretched 4 cycles after release
        add(0, 2'b00, 3, 2'b00, 2'b00, 2'b00, 1);
        add(1, 2'b00, 3, 2'b00, 2'b00, 2'b00, 1);
        add(1, 2'b00, 1, 2'b00, 2'b00, 2'b00, 0);
        add(1, 2'b00, 2, 2'b00, 2'b00, 2'b00, 0);
        // 2: clean press of button 1 held 20 cycles; level after 10 cycles
        add(1, 2'b10, 10, 2'b00, 2'b00, 2'b00, 0);
        add(1, 2'b10, 1, 2'b10, 2'b10, 2'b00, 0);
        add(1, 2'b10, 1, 2'b10, 2'b00, 2'b00, 0);
        add(1, 2'b10, 8, 2'b10, 2'b00, 2'b00, 0);
        add(1, 2'b00, 10, 2'b10, 2'b00, 2'b00, 0);
        add(1, 2'b00, 1, 2'b00, 2'b00, 2'b10, 0);
        add(1, 2'b00, 3, 2'b00, 2'b00, 2'b00, 0);
        // 3: bounce restarts the count; level 10 cycles after the last raw edge
        add(1, 2'b10, 5, 2'b00, 2'b00, 2'b00, 0);
        add(1, 2'b00, 1, 2'b00, 2'b00, 2'b00, 0);
        add(1, 2'b10, 10, 2'b00, 2'b00, 2'b00, 0);
        add(1, 2'b10, 1, 2'b10, 2'b10, 2'b00, 0);
        add(1, 2'b10, 1, 2'b10, 2'b00, 2'b00, 0);
        add(1, 2'b00, 11, 2'b00, 2'b00, 2'b10, 0);
        add(1, 2'b00, 2, 2'b00, 2'b00, 2'b00, 0);
        // 4: button 0 drives soc_reset, stretched 4 cycles after level falls
        add(1, 2'b01, 10, 2'b00, 2'b00, 2'b00, 0);
        add(1, 2'b01, 1, 2'b01, 2'b01, 2'b00, 1);
        add(1, 2'b01, 1, 2'b01, 2'b00, 2'b00, 1);
        add(1, 2'b00, 10, 2'b01, 2'b00, 2'b00, 1);
        add(1, 2'b00, 1, 2'b00, 2'b00, 2'b01, 1);
        add(1, 2'b00, 3, 2'b00, 2'b00, 2'b00, 1);
        add(1, 2'b00, 1, 2'b00, 2'b00, 2'b00, 0);
        // 5: press button 1 up to count=5 in CHK_PRESS, then reset
        add(1, 2'b10, 8, 2'b00, 2'b00, 2'b00, 0);
        split = vecs.size() - 1;
        add(0, 2'b10, 2, 2'b00, 2'b00, 2'b00, 1);
        add(1, 2'b10, 3, 2'b00, 2'b00, 2'b00, 1);
        add(1, 2'b10, 1, 2'b00, 2'b00, 2'b00, 0);
        add(1, 2'b10, 6, 2'b00, 2'b00, 2'b00, 0);
        add(1, 2'b10, 1, 2'b10, 2'b10, 2'b00, 0);
        add(1, 2'b00, 11, 2'b00, 2'b00, 2'b10, 0);
        add(1, 2'b00, 2, 2'b00, 2'b00, 2'b00, 0);

        run_vecs(0, split);

        // Asynchronous reset assertion mid-check
        rst_n = 1'b0;
        #1;
        check("async soc_reset", 32'(soc_reset), 32'd1);
        check("async level", 32'(level), 32'd0);
        check("async press", 32'(press), 32'd0);

        run_vecs(split + 1, vecs.size() - 1);

        // 6: hold button 1 for 40 cycles and watch for the long-press pulse
        lp_count = 0;
        lp_at = -1;
        raw = 2'b10;
        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            if (t == 10) check("t6 level before", 32'(level[1]), 32'd0);
            if (t == 11) check("t6 level rise", 32'(level[1]), 32'd1);
            if (long_p[0] !== 1'b0) check("t6 long_press[0]", 32'(long_p[0]), 32'd0);
            if (long_p[1] === 1'b1) begin
                lp_count++;
                if (lp_at < 0) lp_at = t;
            end
        end
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
        exp_long = 1;
        exp_long_at = 31;
`else
        exp_long = 0;
        exp_long_at = -1;
`endif
        check("t6 long count", 32'(lp_count), 32'(exp_long));
        check("t6 long cycle", 32'(lp_at), 32'(exp_long_at));
        raw = 2'b00;
        repeat (11) @(negedge clk);
        check("t6 release level", 32'(level), 32'd0);
        check("t6 release pulse", 32'(release_p), 32'b10);
        repeat (2) @(negedge clk);

        check("press total ch0", 32'(press_cnt[0]), 32'd1);
        check("press total ch1", 32'(press_cnt[1]), 32'd4);
        check("release total ch0", 32'(rel_cnt[0]), 32'd1);
        check("release total ch1", 32'(rel_cnt[1]), 32'd4);
        check("long total ch0", 32'(long_cnt[0]), 32'd0);
        check("long total ch1", 32'(long_cnt[1]), 32'(exp_long));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
